// File: rtl/dmx_tx.sv
// DMX512 transmitter: BREAK, Mark-After-Break, then start code plus up to 512 slots, 8N2 LSB first.
// Slot bytes are fetched one at a time from a synchronous frame buffer through slot_addr/slot_data.
module dmx_tx #(
    parameter int CLK_FREQ  = 12090000,
    parameter int BAUD_RATE = 250000,
    parameter int BREAK_US  = 176,
    parameter int MAB_US    = 12,
    parameter int MBB_US    = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [9:0] slot_count,
    output logic [9:0] slot_addr,
    input  logic [7:0] slot_data,
    output logic       dmx_out,
    output logic       dmx_oe,
    output logic       busy,
    output logic       frame_done
);
    localparam int BIT_T = CLK_FREQ / BAUD_RATE;
    localparam int CPU   = CLK_FREQ / 1000000;
    localparam int BRK_T = CPU * BREAK_US;
    localparam int MAB_T = CPU * MAB_US;
    localparam int MBB_T = CPU * MBB_US;
    localparam int MAX_A = (BRK_T > MAB_T) ? BRK_T : MAB_T;
    localparam int MAX_B = (MAX_A > MBB_T) ? MAX_A : MBB_T;
    localparam int MAX_T = (MAX_B > 2 * BIT_T) ? MAX_B : 2 * BIT_T;
    localparam int TW    = $clog2(MAX_T) + 1;

    typedef enum logic [2:0] {IDLE, BREAK, MAB, START, DATA, STOP, MBB} state_t;

    // Timer load value for an N-cycle stay; N=0 still costs one transition cycle.
    function automatic logic [TW-1:0] ld(input int n);
        return (n > 0) ? TW'(n - 1) : '0;
    endfunction

    state_t          state;
    logic [TW-1:0]   timer;
    logic [9:0]      n_slots;
    logic [9:0]      idx;
    logic [9:0]      idx_nx;
    logic [9:0]      sc_clamped;
    logic [7:0]      shift_reg;
    logic [2:0]      bit_cnt;

    assign idx_nx = idx + 10'd1;

    always_comb begin
        sc_clamped = slot_count;
        if (slot_count == 10'd0)
            sc_clamped = 10'd1;
        else if (slot_count > 10'd513)
            sc_clamped = 10'd513;
    end

    always_ff @(posedge clk) begin
        frame_done <= 1'b0;
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            n_slots   <= 10'd0;
            idx       <= 10'd0;
            shift_reg <= 8'd0;
            bit_cnt   <= 3'd0;
            slot_addr <= 10'd0;
            dmx_out   <= 1'b1;
            dmx_oe    <= 1'b0;
            busy      <= 1'b0;
        end else if (enable && (state == IDLE || (state == MBB && timer == '0))) begin
            // enable is only looked at here, so a frame in flight always completes
            state     <= BREAK;
            timer     <= ld(BRK_T);
            n_slots   <= sc_clamped;
            idx       <= 10'd0;
            slot_addr <= 10'd0;
            dmx_out   <= 1'b0;
            dmx_oe    <= 1'b1;
            busy      <= 1'b1;
        end else begin
            case (state)
                IDLE: ;
                BREAK:
                    if (timer == '0) begin
                        state   <= MAB;
                        dmx_out <= 1'b1;
                        timer   <= ld(MAB_T);
                    end else
                        timer <= timer - 1'b1;
                MAB:
                    if (timer == '0) begin
                        state     <= START;
                        dmx_out   <= 1'b0;
                        shift_reg <= slot_data;
                        timer     <= ld(BIT_T);
                    end else
                        timer <= timer - 1'b1;
                START:
                    if (timer == '0) begin
                        state   <= DATA;
                        dmx_out <= shift_reg[0];
                        bit_cnt <= 3'd0;
                        timer   <= ld(BIT_T);
                    end else
                        timer <= timer - 1'b1;
                DATA:
                    if (timer == '0) begin
                        if (bit_cnt == 3'd7) begin
                            state     <= STOP;
                            dmx_out   <= 1'b1;
                            timer     <= ld(2 * BIT_T);
                            // prefetch the next slot; the stop bits cover the RAM latency
                            slot_addr <= (idx == 10'd512) ? idx : idx_nx;
                        end else begin
                            dmx_out   <= shift_reg[1];
                            shift_reg <= {1'b0, shift_reg[7:1]};
                            bit_cnt   <= bit_cnt + 3'd1;
                            timer     <= ld(BIT_T);
                        end
                    end else
                        timer <= timer - 1'b1;
                STOP:
                    if (timer == '0) begin
                        if (idx_nx < n_slots) begin
                            idx       <= idx_nx;
                            state     <= START;
                            dmx_out   <= 1'b0;
                            shift_reg <= slot_data;
                            timer     <= ld(BIT_T);
                        end else begin
                            frame_done <= 1'b1;
                            state      <= MBB;
                            timer      <= ld(MBB_T);
                        end
                    end else
                        timer <= timer - 1'b1;
                MBB:
                    if (timer == '0) begin
                        state  <= IDLE;
                        dmx_oe <= 1'b0;
                        busy   <= 1'b0;
                    end else
                        timer <= timer - 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmx_tx.sv
// Bench for dmx_tx: a default-timing instance and a fast-clock instance (MBB_US=100),
// line samples are decoded as a UART against a frame-buffer model.
module tb_dmx_tx;
    localparam int D_CLK = 12090000;
    localparam int F_CLK = 1000000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       en_d = 1'b0, en_f = 1'b0;
    logic [9:0] sc_d = '0, sc_f = '0;
    logic [9:0] addr_d, addr_f;
    logic [7:0] data_d, data_f;
    logic       out_d, oe_d, busy_d, fd_d;
    logic       out_f, oe_f, busy_f, fd_f;
    logic [7:0] ram [0:1023];

    always @(posedge clk) begin
        data_d <= ram[addr_d];
        data_f <= ram[addr_f];
    end

    dmx_tx #(.CLK_FREQ(D_CLK)) u_dut_d (
        .clk(clk), .rst(rst), .enable(en_d), .slot_count(sc_d), .slot_addr(addr_d),
        .slot_data(data_d), .dmx_out(out_d), .dmx_oe(oe_d), .busy(busy_d), .frame_done(fd_d));

    dmx_tx #(.CLK_FREQ(F_CLK), .MBB_US(100)) u_dut_f (
        .clk(clk), .rst(rst), .enable(en_f), .slot_count(sc_f), .slot_addr(addr_f),
        .slot_data(data_f), .dmx_out(out_f), .dmx_oe(oe_f), .busy(busy_f), .frame_done(fd_f));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor mux and expected timing of the selected instance
    bit sel = 1'b0;
    logic m_out, m_fd;
    logic [9:0] m_addr;
    always_comb begin
        m_out  = sel ? out_f  : out_d;
        m_fd   = sel ? fd_f   : fd_d;
        m_addr = sel ? addr_f : addr_d;
    end

    int bt, bk, mb, mbb;
    task automatic set_sel(input bit s);
        int f;
        sel = s;
        f   = s ? F_CLK : D_CLK;
        bt  = f / 250000;
        bk  = (f / 1000000) * 176;
        mb  = (f / 1000000) * 12;
        mbb = (f / 1000000) * (s ? 100 : 0);
    endtask

    bit line[$];
    int fd_at, addr_max, gap;
    bit cap_ok;

    // Waits for the BREAK falling edge, then records the line once per cycle up to frame_done.
    task automatic capture(input string tag);
        cap_ok = 1'b0;
        line.delete();
        addr_max = 0;
        gap = 0;
        fd_at = -1;
        do begin
            @(negedge clk);
            gap++;
        end while (m_out !== 1'b0 && gap < 5000);
        if (m_out !== 1'b0) begin
            chk({tag, " break_start"}, 1, 0);
            return;
        end
        for (int k = 0; k < 40000; k++) begin
            line.push_back(m_out);
            if (int'(m_addr) > addr_max) addr_max = int'(m_addr);
            if (m_fd === 1'b1) begin
                fd_at = k;
                break;
            end
            @(negedge clk);
        end
        if (fd_at < 0) begin
            chk({tag, " frame_done_timeout"}, 1, 0);
            return;
        end
        cap_ok = 1'b1;
    endtask

    task automatic check_frame(input string tag, input int n, input int exp_gap);
        int z, o;
        if (!cap_ok) return;
        chk({tag, " gap"}, gap, exp_gap);
        z = 0;
        while (z < line.size() && line[z] == 1'b0) z++;
        chk({tag, " break_len"}, z, bk);
        o = 0;
        while (z + o < line.size() && line[z + o] == 1'b1) o++;
        chk({tag, " mab_len"}, o, mb);
        chk({tag, " frame_len"}, fd_at, bk + mb + n * 11 * bt);
        chk({tag, " addr_peak"}, addr_max, (n < 512) ? n : 512);
        for (int s = 0; s < n; s++) begin
            logic [10:0] w, e;
            for (int j = 0; j < 11; j++) begin
                int p;
                p = bk + mb + s * 11 * bt + j * bt + bt / 2;
                w[j] = (p < line.size()) ? line[p] : 1'b0;
            end
            e = {2'b11, ram[s], 1'b0};
            chk($sformatf("%s slot%0d", tag, s), int'(w), int'(e));
        end
    endtask

    typedef struct {
        int sc;
        int n;
        int pat;
    } vec_t;
    vec_t tbl [5];

    initial begin
        int t, lows;
        tbl[0] = '{sc: 3,   n: 3,   pat: 0};
        tbl[1] = '{sc: 0,   n: 1,   pat: 0};
        tbl[2] = '{sc: 513, n: 513, pat: 1};
        tbl[3] = '{sc: 700, n: 513, pat: 0};
        tbl[4] = '{sc: 2,   n: 2,   pat: 1};
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;

        repeat (3) @(negedge clk);
        chk("rst dmx_out", out_d, 1);
        chk("rst dmx_oe", oe_d, 0);
        chk("rst busy", busy_d, 0);
        chk("rst frame_done", fd_d, 0);
        chk("rst slot_addr", addr_d, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle dmx_oe", oe_d, 0);

        // Defaults, three slots {00,55,FF}
        set_sel(1'b0);
        ram[0] = 8'h00; ram[1] = 8'h55; ram[2] = 8'hFF;
        sc_d = 10'd3;
        en_d = 1'b1;
        capture("d3");
        chk("d3 oe_in_frame", oe_d, 1);
        check_frame("d3", 3, 1);

        // Back-to-back frame of 10 random slots; enable dropped mid-frame
        sc_d = 10'd10;
        for (int i = 0; i < 10; i++) ram[i] = 8'($urandom);
        fork
            capture("d10");
            begin
                int w;
                w = 0;
                while (addr_d != 10'd2 && w < 20000) begin
                    @(negedge clk);
                    w++;
                end
                en_d = 1'b0;
            end
        join
        check_frame("d10", 10, 1);
        repeat (2) @(negedge clk);
        chk("drop busy", busy_d, 0);
        chk("drop dmx_oe", oe_d, 0);
        chk("drop dmx_out", out_d, 1);
        lows = 0;
        repeat (3000) begin
            @(negedge clk);
            if (out_d !== 1'b1) lows++;
        end
        chk("drop no_new_break", lows, 0);

        // Reset inside DATA of slot 5, then a clean frame
        for (int i = 0; i < 10; i++) ram[i] = 8'($urandom);
        en_d = 1'b1;
        t = 0;
        while (addr_d != 10'd5 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk("rst_mid reached_slot5", addr_d, 5);
        repeat (5 * bt) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid dmx_out", out_d, 1);
        chk("rst_mid dmx_oe", oe_d, 0);
        chk("rst_mid slot_addr", addr_d, 0);
        chk("rst_mid busy", busy_d, 0);
        rst = 1'b0;
        capture("d_rst");
        check_frame("d_rst", 10, 1);
        en_d = 1'b0;

        // Fast instance: slot_count table, frames back-to-back with a 100-cycle MBB
        set_sel(1'b1);
        for (int r = 0; r < 5; r++) begin
            sc_f = 10'(tbl[r].sc);
            for (int i = 0; i < 513; i++)
                ram[i] = (tbl[r].pat == 1) ? 8'(i) : 8'($urandom);
            en_f = 1'b1;
            capture($sformatf("f%0d", r));
            check_frame($sformatf("f%0d", r), tbl[r].n, (r == 0) ? 1 : mbb);
        end
        en_f = 1'b0;
        repeat (mbb + 3) @(negedge clk);
        chk("f end busy", busy_f, 0);
        chk("f end dmx_oe", oe_f, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
